missile_launcher: RTL

//  Player-side producer of the enemy-array `hit` strobe.
//  - Launches one missile from the ship on `fire` and moves it up one step per frame.
//  - Detects pixel-level overlap between the missile and `enemy_on` during the raster scan.
//  - Emits a single-Clk `hit` pulse at the next frame boundary.
//  - Also drives the missile sprite colour toward the colour mapper.

---
 rtl/space_invaders_pkg.sv | 20 ++
 rtl/missile_launcher_if.sv | 34 +++
 rtl/frame_tick_sync.sv | 35 +++
 rtl/missile_launcher.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/space_invaders_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : space_invaders_pkg
//  Brief    : Shared types and screen geometry for the space-invaders blocks.
//  Revision : 1.0  initial release
// ============================================================================
package space_invaders_pkg;

   localparam int COORD_W  = 10;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLYING   = 2'd1,
      COOLDOWN = 2'd2
   } missile_state_t;

endpackage : space_invaders_pkg
`default_nettype wire

// File: rtl/missile_launcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : missile_launcher_if
//  Brief    : Player controls, raster position and missile sprite outputs.
//             master = game/video side, slave = missile_launcher.
//  Revision : 1.0  initial release
// ============================================================================
interface missile_launcher_if;
   import space_invaders_pkg::*;

   logic               fire;
   logic               is_playing;
   logic [COORD_W-1:0] ship_x;
   logic [COORD_W-1:0] DrawX;
   logic [COORD_W-1:0] DrawY;
   logic               enemy_on;
   logic               hit;
   logic               missile_on;
   logic [7:0]         missile_R;
   logic [7:0]         missile_G;
   logic [7:0]         missile_B;

   modport master (
      output fire, is_playing, ship_x, DrawX, DrawY, enemy_on,
      input  hit, missile_on, missile_R, missile_G, missile_B
   );

   modport slave (
      input  fire, is_playing, ship_x, DrawX, DrawY, enemy_on,
      output hit, missile_on, missile_R, missile_G, missile_B
   );

endinterface : missile_launcher_if
`default_nettype wire

// File: rtl/frame_tick_sync.sv
`default_nettype none
// ============================================================================
//  Module   : frame_tick_sync
//  Brief    : 2-FF synchroniser for the asynchronous frame strobe plus a
//             rising-edge detector; o_tick is high for one Clk per frame.
//  Revision : 1.0  initial release
// ============================================================================
module frame_tick_sync (
   input  wire  Clk,
   input  wire  Reset_n,
   input  wire  i_frame_clk,
   output logic o_tick
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Two synchroniser stages followed by one delay stage for edge detection
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_frame_clk;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_tick = r_sync & ~r_prev;

endmodule : frame_tick_sync
`default_nettype wire

// File: rtl/missile_launcher.sv
`default_nettype none
// ============================================================================
//  Module   : missile_launcher
//  Brief    : Launches a single player missile, moves it up once per frame,
//             latches pixel overlap with the enemy array and issues a one-Clk
//             hit pulse at the following frame tick. Drives sprite colour.
//  Options  : MISSILE_COOLDOWN_EN - after a missile ends, block firing for
//             COOLDOWN_FRAMES frame ticks.
//  Revision : 1.0  initial release
// ============================================================================
module missile_launcher
   import space_invaders_pkg::*;
#(
   parameter int         MISSILE_W       = 2,
   parameter int         MISSILE_H       = 8,
   parameter int         SPEED           = 4,
   parameter int         SHIP_Y          = 440,
   parameter int         COOLDOWN_FRAMES = 8,
   parameter logic [7:0] COLOR_R         = 8'hFF,
   parameter logic [7:0] COLOR_G         = 8'hFF,
   parameter logic [7:0] COLOR_B         = 8'h00
) (
   input  wire               Clk,
   input  wire               Reset_n,
   input  wire               frame_clk,
   missile_launcher_if.slave bus
);

   localparam logic [COORD_W-1:0] c_LAUNCH_Y = COORD_W'(SHIP_Y - MISSILE_H);
   localparam logic [COORD_W-1:0] c_SPEED    = COORD_W'(SPEED);
   localparam logic [COORD_W:0]   c_W_EXT    = (COORD_W+1)'(MISSILE_W);
   localparam logic [COORD_W:0]   c_H_EXT    = (COORD_W+1)'(MISSILE_H);

`ifdef MISSILE_COOLDOWN_EN
   localparam int                 c_CD_W      = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
   localparam logic [c_CD_W-1:0]  c_CD_LAST   = c_CD_W'(COOLDOWN_FRAMES - 1);
   localparam missile_state_t     c_END_STATE = COOLDOWN;
   logic [c_CD_W-1:0]             r_cd_cnt;
`else
   localparam missile_state_t     c_END_STATE = IDLE;
   localparam int                 c_unused_cooldown = COOLDOWN_FRAMES;
`endif

   missile_state_t      r_state;
   logic [COORD_W-1:0]  r_x;
   logic [COORD_W-1:0]  r_y;
   logic                r_collide;
   logic                r_hit;
   logic                w_tick;
   logic                w_missile_on;

   frame_tick_sync u_tick_sync (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .i_frame_clk (frame_clk),
      .o_tick      (w_tick)
   );

   // Sprite hit-test; 11-bit compare so x+W / y+H cannot wrap at the top of the range
   always_comb begin
      w_missile_on = (r_state == FLYING)
                  && ({1'b0, bus.DrawX} >= {1'b0, r_x})
                  && ({1'b0, bus.DrawX} <  ({1'b0, r_x} + c_W_EXT))
                  && ({1'b0, bus.DrawY} >= {1'b0, r_y})
                  && ({1'b0, bus.DrawY} <  ({1'b0, r_y} + c_H_EXT));
   end

   // Missile FSM: launch, per-frame motion, collision latch and hit pulse
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= IDLE;
         r_x       <= '0;
         r_y       <= '0;
         r_collide <= 1'b0;
         r_hit     <= 1'b0;
`ifdef MISSILE_COOLDOWN_EN
         r_cd_cnt  <= '0;
`endif
      end else begin
         r_hit <= 1'b0;
`ifdef MISSILE_COOLDOWN_EN
         if (r_state != COOLDOWN)
            r_cd_cnt <= '0;
`endif
         if (!bus.is_playing) begin
            // Leaving play abandons the missile and any pending collision
            r_state   <= IDLE;
            r_collide <= 1'b0;
         end else if (w_tick) begin
            // The latched collision is consumed here and rearmed for the new frame
            r_collide <= 1'b0;
            case (r_state)
               IDLE: begin
                  if (bus.fire) begin
                     r_state <= FLYING;
                     r_x     <= bus.ship_x;
                     r_y     <= c_LAUNCH_Y;
                  end
               end
               FLYING: begin
                  if (r_collide) begin
                     r_hit   <= 1'b1;
                     r_state <= c_END_STATE;
                  end else if (r_y < c_SPEED) begin
                     r_state <= c_END_STATE;
                  end else begin
                     r_y <= r_y - c_SPEED;
                  end
               end
`ifdef MISSILE_COOLDOWN_EN
               COOLDOWN: begin
                  // The last cooldown tick may launch directly so a held button
                  // refires exactly COOLDOWN_FRAMES ticks after the missile ended
                  if (r_cd_cnt == c_CD_LAST) begin
                     if (bus.fire) begin
                        r_state <= FLYING;
                        r_x     <= bus.ship_x;
                        r_y     <= c_LAUNCH_Y;
                     end else begin
                        r_state <= IDLE;
                     end
                  end else begin
                     r_cd_cnt <= r_cd_cnt + 1'b1;
                  end
               end
`endif
               default: r_state <= IDLE;
            endcase
         end else if (w_missile_on && bus.enemy_on) begin
            r_collide <= 1'b1;
         end
      end
   end

   assign bus.hit        = r_hit;
   assign bus.missile_on = w_missile_on;
   assign bus.missile_R  = w_missile_on ? COLOR_R : 8'h00;
   assign bus.missile_G  = w_missile_on ? COLOR_G : 8'h00;
   assign bus.missile_B  = w_missile_on ? COLOR_B : 8'h00;

endmodule : missile_launcher
`default_nettype wire
